// File: rtl/parity_rx_checker.sv
// Deserialises LSB-first parity frames, checks parity and keeps saturating frame/error counts.
// Optional sticky error flag with clear input when PARITY_STICKY_ERR_EN is defined.
module parity_rx_checker #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              sdata,
`ifdef PARITY_STICKY_ERR_EN
  input  logic              err_clr,
  output logic              err_sticky,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              par_err,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int   IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic ODD   = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              done;
  logic              perr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A sof in PAR restarts the frame, so that frame never completes.
  always_comb begin
    done = (state == PAR) && !sof;
    perr = ((^shreg) ^ ODD) != sdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      idx         <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      frame_abort <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
`ifdef PARITY_STICKY_ERR_EN
      err_sticky  <= 1'b0;
`endif
    end else begin
      data_valid  <= 1'b0;
      frame_abort <= 1'b0;
      if (sof) begin
        frame_abort <= (state != IDLE);
        shreg       <= {{(DATA_W-1){1'b0}}, sdata};
        idx         <= IDX_W'(1);
        state       <= DATA;
      end else begin
        case (state)
          DATA: begin
            shreg[idx] <= sdata;
            if (idx == IDX_W'(DATA_W - 1)) state <= PAR;
            else idx <= idx + IDX_W'(1);
          end
          PAR:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (done) begin
        data_out   <= shreg;
        par_err    <= perr;
        data_valid <= 1'b1;
        frame_cnt  <= sat_inc(frame_cnt);
      end

`ifdef PARITY_STICKY_ERR_EN
      // A failing frame in the same cycle as a clear leaves one error recorded.
      if (done && perr) begin
        err_cnt    <= err_clr ? CNT_W'(1) : sat_inc(err_cnt);
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end
`else
      if (done && perr) err_cnt <= sat_inc(err_cnt);
`endif
    end
  end

endmodule

// File: tb/tb_parity_rx_checker.sv
// Directed bench: frame-level model compared every cycle, plus literal expectations.
module tb_parity_rx_checker;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof = 1'b0;
  logic sdata = 1'b0;
  logic err_clr = 1'b0;

  logic [DW-1:0] data_out, data_out2;
  logic          data_valid, data_valid2, par_err, par_err2, frame_abort, frame_abort2;
  logic [7:0]    frame_cnt, err_cnt;
  logic [1:0]    frame_cnt2, err_cnt2;
  logic          err_sticky, err_sticky2;

  always #5 clk = ~clk;

  parity_rx_checker #(.DATA_W(DW), .ODD_PARITY(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .sdata(sdata),
`ifdef PARITY_STICKY_ERR_EN
    .err_clr(err_clr), .err_sticky(err_sticky),
`endif
    .data_out(data_out), .data_valid(data_valid), .par_err(par_err),
    .frame_abort(frame_abort), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  parity_rx_checker #(.DATA_W(DW), .ODD_PARITY(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sof(sof), .sdata(sdata),
`ifdef PARITY_STICKY_ERR_EN
    .err_clr(err_clr), .err_sticky(err_sticky2),
`endif
    .data_out(data_out2), .data_valid(data_valid2), .par_err(par_err2),
    .frame_abort(frame_abort2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_cyc[$];
  int abort_n = 0;

  // Frame-level model: bits collected since the last sof.
  bit       bits_q[$];
  int       m_dout, m_dv, m_perr, m_abort, m_fc, m_ec, m_fc2, m_ec2, m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  task automatic model_edge(input bit s, input bit d, input bit c);
    int  data, ones;
    bit  p, err, fin;
    m_dv = 0; m_abort = 0; fin = 0; err = 0;
    if (!rst_n) begin
      bits_q.delete();
      m_dout = 0; m_perr = 0; m_fc = 0; m_ec = 0; m_fc2 = 0; m_ec2 = 0; m_st = 0;
      return;
    end
    if (s) begin
      if (bits_q.size() > 0) m_abort = 1;
      bits_q.delete();
      bits_q.push_back(d);
    end else if (bits_q.size() > 0) begin
      bits_q.push_back(d);
      if (bits_q.size() == DW + 1) begin
        data = 0;
        for (int i = 0; i < DW; i++) data += int'(bits_q[i]) * (1 << i);
        p    = bits_q[DW];
        ones = $countones(data) + int'(p);
        err  = (ones % 2) != 0;
        fin  = 1;
        bits_q.delete();
        m_dout = data; m_perr = int'(err); m_dv = 1;
        m_fc = sat(m_fc, 255); m_fc2 = sat(m_fc2, 3);
      end
    end
`ifdef PARITY_STICKY_ERR_EN
    if (fin && err) begin
      m_ec  = c ? 1 : sat(m_ec, 255);
      m_ec2 = c ? 1 : sat(m_ec2, 3);
      m_st  = 1;
    end else if (c) begin
      m_ec = 0; m_ec2 = 0; m_st = 0;
    end
`else
    if (fin && err) begin
      m_ec = sat(m_ec, 255); m_ec2 = sat(m_ec2, 3);
    end
`endif
  endtask

  task automatic compare_all();
    chk("data_out",    32'(data_out),    32'(m_dout));
    chk("data_valid",  32'(data_valid),  32'(m_dv));
    chk("par_err",     32'(par_err),     32'(m_perr));
    chk("frame_abort", 32'(frame_abort), 32'(m_abort));
    chk("frame_cnt",   32'(frame_cnt),   32'(m_fc));
    chk("err_cnt",     32'(err_cnt),     32'(m_ec));
    chk("frame_cnt_w2", 32'(frame_cnt2), 32'(m_fc2));
    chk("err_cnt_w2",  32'(err_cnt2),    32'(m_ec2));
`ifdef PARITY_STICKY_ERR_EN
    chk("err_sticky",  32'(err_sticky),  32'(m_st));
    chk("err_sticky_w2", 32'(err_sticky2), 32'(m_st));
`endif
  endtask

  // Drive one cycle; outputs seen afterwards belong to cycle cyc.
  task automatic step(input bit s, input bit d, input bit c = 1'b0);
    sof = s; sdata = d; err_clr = c;
    @(posedge clk);
    model_edge(s, d, c);
    #1;
    cyc++;
    if (data_valid === 1'b1) dv_cyc.push_back(cyc);
    if (frame_abort === 1'b1) abort_n++;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit p, input bit c = 1'b0);
    for (int i = 0; i < DW; i++) step(i == 0, b[i]);
    step(1'b0, p, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int start, n0, a0;
    logic [7:0] b;
    logic [1:0] exp_e2 [5];
    exp_e2[0] = 2'd1; exp_e2[1] = 2'd2; exp_e2[2] = 2'd3; exp_e2[3] = 2'd3; exp_e2[4] = 2'd3;

    // 1: reset state then a single good frame
    do_reset();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    step(1'b0, 1'b1);
    start = cyc;
    n0 = dv_cyc.size();
    send_frame(8'h04, 1'b1);
    chk("t1_dv_count", 32'(dv_cyc.size() - n0), 32'd1);
    chk("t1_latency", 32'(dv_cyc[n0] - start), 32'd9);
    chk("t1_data_out", 32'(data_out), 32'h04);
    chk("t1_par_err", 32'(par_err), 32'h0);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // 2: back-to-back frames
    n0 = dv_cyc.size();
    send_frame(8'hBD, 1'b0);
    send_frame(8'h64, 1'b1);
    send_frame(8'hFF, 1'b0);
    chk("t2_dv_count", 32'(dv_cyc.size() - n0), 32'd3);
    chk("t2_gap_a", 32'(dv_cyc[n0+1] - dv_cyc[n0]), 32'd9);
    chk("t2_gap_b", 32'(dv_cyc[n0+2] - dv_cyc[n0+1]), 32'd9);
    chk("t2_data_out", 32'(data_out), 32'hFF);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd4);
    step(1'b0, 1'b0);
    chk("t2_data_held", 32'(data_out), 32'hFF);

    // 3: parity error, then a good frame
    send_frame(8'hFF, 1'b1);
    chk("t3_par_err", 32'(par_err), 32'h1);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    send_frame(8'h04, 1'b1);
    chk("t3b_par_err", 32'(par_err), 32'h0);
    chk("t3b_err_cnt", 32'(err_cnt), 32'd1);
    chk("t3b_frame_cnt", 32'(frame_cnt), 32'd6);

    // 4: sof restart at bit 4
    n0 = dv_cyc.size();
    a0 = abort_n;
    b = 8'hBD;
    for (int i = 0; i < 4; i++) step(i == 0, b[i]);
    send_frame(8'h64, 1'b1);
    step(1'b0, 1'b0);
    chk("t4_abort_count", 32'(abort_n - a0), 32'd1);
    chk("t4_dv_count", 32'(dv_cyc.size() - n0), 32'd1);
    chk("t4_data_out", 32'(data_out), 32'h64);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd7);

    // 5: reset mid-frame
    a0 = abort_n;
    n0 = dv_cyc.size();
    b = 8'h04;
    for (int i = 0; i < 5; i++) step(i == 0, b[i]);
    rst_n = 1'b0;
    step(1'b0, b[5]);
    rst_n = 1'b1;
    chk("t5_data_out", 32'(data_out), 32'h0);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_err_cnt", 32'(err_cnt), 32'd0);
    step(1'b0, b[6]);
    step(1'b0, b[7]);
    chk("t5_no_abort", 32'(abort_n - a0), 32'd0);
    chk("t5_no_dv", 32'(dv_cyc.size() - n0), 32'd0);
    send_frame(8'h04, 1'b1);
    chk("t5_data_out_b", 32'(data_out), 32'h04);
    chk("t5_frame_cnt_b", 32'(frame_cnt), 32'd1);

    // 6: saturation on the narrow-counter instance
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h04, 1'b0);
      chk("t6_err_cnt_w2", 32'(err_cnt2), 32'(exp_e2[k]));
    end
    chk("t6_frame_cnt_w2", 32'(frame_cnt2), 32'd3);
    chk("t6_err_cnt_w8", 32'(err_cnt), 32'd5);
`ifdef PARITY_STICKY_ERR_EN
    chk("t6_sticky_set", 32'(err_sticky), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t6_clr_cnt", 32'(err_cnt2), 32'd0);
    chk("t6_clr_sticky", 32'(err_sticky2), 32'd0);
    send_frame(8'h04, 1'b0, 1'b1);
    chk("t6_clrset_sticky", 32'(err_sticky), 32'd1);
    chk("t6_clrset_cnt", 32'(err_cnt), 32'd1);
`endif
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
